// File: rtl/systolic_result_postproc_pkg.sv
// Shared constants, FSM encoding and the lane saturation helper for the
// systolic result post-processor.
package systolic_pkg;
  localparam int LANES      = 16;
  localparam int LANE_W     = 8;
  localparam int DATA_W     = LANES * LANE_W;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 12;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int OCC_W      = PTR_W + 2;

  localparam logic [7:0] CSR_CTRL   = 8'h00;
  localparam logic [7:0] CSR_BEATS  = 8'h01;
  localparam logic [7:0] CSR_STATUS = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // 9-bit signed sum clamped back into int8 range.
  function automatic logic [7:0] sat_int8(input logic [7:0] x, input logic [7:0] b);
    logic [8:0] s;
    s = {x[7], x} + {b[7], b};
    if (s[8:7] == 2'b01)      return 8'h7F;
    else if (s[8:7] == 2'b10) return 8'h80;
    else                      return s[7:0];
  endfunction
endpackage

// File: rtl/systolic_result_postproc_if.sv
// CSR, result stream in/out and irq bundle of the post-processor.
interface systolic_result_postproc_if;
  import systolic_pkg::*;
  logic [7:0]        csr_address;
  logic              csr_write;
  logic              csr_read;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;
  logic [DATA_W-1:0] st_in_data;
  logic              st_in_valid;
  logic              st_in_ready;
  logic [DATA_W-1:0] st_out_data;
  logic              st_out_valid;
  logic              st_out_ready;
  logic              st_out_startofpacket;
  logic              st_out_endofpacket;
  logic              irq;

  modport slave (
    input  csr_address, csr_write, csr_read, csr_writedata, st_in_data, st_in_valid, st_out_ready,
    output csr_readdata, st_in_ready, st_out_data, st_out_valid, st_out_startofpacket,
           st_out_endofpacket, irq
  );
  modport master (
    output csr_address, csr_write, csr_read, csr_writedata, st_in_data, st_in_valid, st_out_ready,
    input  csr_readdata, st_in_ready, st_out_data, st_out_valid, st_out_startofpacket,
           st_out_endofpacket, irq
  );
endinterface

// File: rtl/systolic_result_postproc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;
endmodule

// File: rtl/systolic_result_postproc.sv
// Bias-add / saturate post-processor with framed FWFT output and tile irq.
// Optional build macro: POSTPROC_RELU_EN clamps negative lanes to zero.
module systolic_result_postproc
  import systolic_pkg::*;
(
  input  logic                        clock_sink,
  input  logic                        reset_sink_reset_n,
  systolic_result_postproc_if.slave   bus
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beats_q, beats_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [LANE_W-1:0]  bias_q [LANES];
  logic [LANE_W-1:0]  bias_d [LANES];
  logic               irq_q, irq_d;
  logic               pipe_valid_q, pipe_valid_d;
  logic [DATA_W-1:0]  pipe_data_q, pipe_data_d, biased;
  logic [DATA_W-1:0]  fifo_rd_data;
  logic               fifo_empty;
  logic [PTR_W:0]     fifo_count;
  logic [OCC_W-1:0]   occ;
  logic               busy, in_ready, in_fire, out_valid, out_fire, sop, eop;
  logic               ctrl_wr, start, irq_clr, irq_set;
  logic [19:0]        unused_wdata;

  assign busy      = (state_q != ST_IDLE);
  assign occ       = {1'b0, fifo_count} + {{(OCC_W-1){1'b0}}, pipe_valid_q};
  assign in_ready  = (state_q == ST_RUN) && (in_cnt_q < beats_q) && (occ < OCC_W'(FIFO_DEPTH));
  assign in_fire   = bus.st_in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign out_fire  = out_valid && bus.st_out_ready;
  assign sop       = out_valid && (out_cnt_q == '0);
  assign eop       = out_valid && (out_cnt_q == beats_q - CNT_W'(1));
  assign ctrl_wr   = bus.csr_write && (bus.csr_address == CSR_CTRL);
  assign start     = ctrl_wr && bus.csr_writedata[0];
  assign irq_clr   = ctrl_wr && bus.csr_writedata[1];
  assign unused_wdata = bus.csr_writedata[31:12];

  always_comb begin
    biased = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [LANE_W-1:0] y;
      y = sat_int8(bus.st_in_data[DATA_W-1-i*LANE_W -: LANE_W], bias_q[i]);
`ifdef POSTPROC_RELU_EN
      if (y[LANE_W-1]) y = '0;
`endif
      biased[DATA_W-1-i*LANE_W -: LANE_W] = y;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    irq_d        = irq_q;
    irq_set      = 1'b0;
    pipe_valid_d = in_fire;
    pipe_data_d  = in_fire ? biased : pipe_data_q;
    for (int i = 0; i < LANES; i++) begin
      bias_d[i] = bias_q[i];
      if (!busy && bus.csr_write && bus.csr_address[7:4] == 4'h1 && bus.csr_address[3:0] == 4'(i))
        bias_d[i] = bus.csr_writedata[LANE_W-1:0];
    end
    if (!busy && bus.csr_write && bus.csr_address == CSR_BEATS)
      beats_d = bus.csr_writedata[CNT_W-1:0];
    if (in_fire)  in_cnt_d  = in_cnt_q + 1'b1;
    if (out_fire) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: if (start && beats_q != '0) begin
        state_d   = ST_RUN;
        in_cnt_d  = '0;
        out_cnt_d = '0;
      end
      ST_RUN:   if (in_fire && in_cnt_q == beats_q - CNT_W'(1)) state_d = ST_DRAIN;
      // The EOP pop is necessarily the last buffered beat, so FIFO and pipe are empty afterwards.
      ST_DRAIN: if (out_fire && eop) begin
        state_d = ST_IDLE;
        irq_set = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (irq_clr) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge clock_sink or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q      <= ST_IDLE;
      beats_q      <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      irq_q        <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      for (int i = 0; i < LANES; i++) bias_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      irq_q        <= irq_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      for (int i = 0; i < LANES; i++) bias_q[i] <= bias_d[i];
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clock_sink),
    .rst_n   (reset_sink_reset_n),
    .wr_en   (pipe_valid_q),
    .wr_data (pipe_data_q),
    .rd_en   (out_fire),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    bus.csr_readdata = '0;
    if (bus.csr_read) begin
      if (bus.csr_address == CSR_BEATS)
        bus.csr_readdata = {20'b0, beats_q};
      else if (bus.csr_address == CSR_STATUS)
        bus.csr_readdata = {4'b0, out_cnt_q, 14'b0, irq_q, busy};
      else if (bus.csr_address[7:4] == 4'h1)
        bus.csr_readdata = {24'b0, bias_q[bus.csr_address[3:0]]};
    end
  end

  assign bus.st_in_ready          = in_ready;
  assign bus.st_out_data          = fifo_rd_data;
  assign bus.st_out_valid         = out_valid;
  assign bus.st_out_startofpacket = sop;
  assign bus.st_out_endofpacket   = eop;
  assign bus.irq                  = irq_q;
endmodule

// File: tb/tb_systolic_result_postproc.sv
// Scoreboard bench for systolic_result_postproc: stimulus pushes expected beats, a monitor pops them.
module tb_systolic_result_postproc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   accepted = 0;
  logic sender_done;
  logic [129:0] exp_q[$];

  always #5 clk = ~clk;

  systolic_result_postproc_if bus();

  systolic_result_postproc dut (
    .clock_sink         (clk),
    .reset_sink_reset_n (rst_n),
    .bus                (bus)
  );

  function automatic void check(input string nm, input logic [129:0] act, input logic [129:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.st_out_valid && bus.st_out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h expected none", bus.st_out_data);
      end else begin
        check("out_beat", {bus.st_out_startofpacket, bus.st_out_endofpacket, bus.st_out_data},
              exp_q.pop_front());
      end
    end
  end

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    bus.csr_address = a; bus.csr_writedata = d; bus.csr_write = 1'b1;
    @(posedge clk); #1;
    bus.csr_write = 1'b0;
  endtask

  task automatic csr_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    bus.csr_address = a; bus.csr_read = 1'b1;
    #1;
    check(nm, {98'b0, bus.csr_readdata}, {98'b0, exp});
    bus.csr_read = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [127:0] e, input logic s, input logic eo);
    int n;
    logic rdy;
    exp_q.push_back({s, eo, e});
    bus.st_in_data = d; bus.st_in_valid = 1'b1; n = 0;
    do begin
      @(negedge clk); rdy = bus.st_in_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 300);
    bus.st_in_valid = 1'b0;
    if (rdy) accepted++; else fail_now("send_beat");
  endtask

  task automatic wait_irq(input string nm);
    int n = 0;
    while (!bus.irq && n < 200) begin @(posedge clk); #1; n++; end
    check(nm, {129'b0, bus.irq}, 130'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, e;
    int n;
    bus.csr_address = '0; bus.csr_write = 0; bus.csr_read = 0; bus.csr_writedata = '0;
    bus.st_in_data = '0; bus.st_in_valid = 0; bus.st_out_ready = 1'b1;
    #23;
    check("rst_outputs", {126'b0, bus.st_in_ready, bus.st_out_valid, bus.st_out_startofpacket,
          bus.st_out_endofpacket}, 130'd0);
    check("rst_irq", {129'b0, bus.irq}, 130'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    csr_chk("rst_status", 8'h02, 32'h0);

    csr_wr(8'h00, 32'h1);
    cycles(2);
    csr_chk("start_beats0_idle", 8'h02, 32'h0);

    // Tile of 4 beats with zero bias; config writes while busy must not land.
    csr_wr(8'h01, 32'd4);
    csr_wr(8'h00, 32'h1);
    csr_chk("busy_after_start", 8'h02, 32'h1);
    csr_wr(8'h01, 32'd7);
    csr_wr(8'h10, 32'h55);
    csr_wr(8'h00, 32'h1);
    d = 128'h0102030405060708090a0b0c0d0e0f10;
    for (int k = 0; k < 4; k++) send_beat(d, d, k == 0, k == 3);
    wait_irq("irq_tile4");
    cycles(1);
    csr_chk("status_tile4", 8'h02, 32'h0004_0002);
    csr_chk("beats_ignored_busy", 8'h01, 32'd4);
    csr_chk("bias_ignored_busy", 8'h10, 32'h0);
    csr_wr(8'h00, 32'h2);
    check("irq_clear", {129'b0, bus.irq}, 130'd0);

    // Saturation at both ends.
    csr_wr(8'h10, 32'h20);
    csr_wr(8'h11, 32'hE0);
    csr_wr(8'h01, 32'd1);
    csr_chk("bias1_rb", 8'h11, 32'hE0);
    csr_wr(8'h00, 32'h1);
    d = 128'h7090_0000_0000_0000_0000_0000_0000_0000;
`ifdef POSTPROC_RELU_EN
    e = 128'h7F00_0000_0000_0000_0000_0000_0000_0000;
`else
    e = 128'h7F80_0000_0000_0000_0000_0000_0000_0000;
`endif
    send_beat(d, e, 1'b1, 1'b1);
    wait_irq("irq_sat");
    cycles(1);
    csr_chk("status_sat", 8'h02, 32'h0001_0002);
    csr_wr(8'h00, 32'h2);

    // Negative lane passthrough vs ReLU.
    csr_wr(8'h10, 32'h0);
    csr_wr(8'h11, 32'h0);
    csr_wr(8'h00, 32'h1);
    d = {16{8'hF0}};
`ifdef POSTPROC_RELU_EN
    e = '0;
`else
    e = {16{8'hF0}};
`endif
    send_beat(d, e, 1'b1, 1'b1);
    wait_irq("irq_relu");
    csr_wr(8'h00, 32'h2);

    // Full stall: 16 beats buffered, then release and drain 32 in order.
    csr_wr(8'h01, 32'd32);
    bus.st_out_ready = 1'b0;
    accepted = 0;
    sender_done = 1'b0;
    csr_wr(8'h00, 32'h1);
    fork
      begin
        for (int k = 0; k < 32; k++) begin
          logic [7:0] b;
          b = 8'(k);
          send_beat({16{b}}, {16{b}}, k == 0, k == 31);
        end
        sender_done = 1'b1;
      end
    join_none
    cycles(40);
    check("stall_accepted", 130'(accepted), 130'd16);
    check("stall_in_ready", {129'b0, bus.st_in_ready}, 130'd0);
    bus.st_out_ready = 1'b1;
    n = 0;
    while (!(sender_done && exp_q.size() == 0) && n < 500) begin @(posedge clk); #1; n++; end
    check("stall_drained", {98'b0, 32'(exp_q.size()), 1'b0, sender_done}, 130'd1);
    wait_irq("irq_stall");
    csr_wr(8'h00, 32'h2);

    // Reset mid-tile, then a fresh 2-beat tile.
    csr_wr(8'h01, 32'd5);
    bus.st_out_ready = 1'b0;
    csr_wr(8'h00, 32'h1);
    d = {16{8'h11}};
    for (int k = 0; k < 3; k++) send_beat(d, d, k == 0, 1'b0);
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {126'b0, bus.st_in_ready, bus.st_out_valid, bus.st_out_startofpacket,
          bus.st_out_endofpacket}, 130'd0);
    check("midreset_irq", {129'b0, bus.irq}, 130'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.st_out_ready = 1'b1;
    @(posedge clk); #1;
    csr_chk("midreset_status", 8'h02, 32'h0);
    csr_chk("midreset_beats", 8'h01, 32'h0);
    csr_wr(8'h01, 32'd2);
    csr_wr(8'h00, 32'h1);
    d = 128'h00112233445566770011223344556677;
    send_beat(d, d, 1'b1, 1'b0);
    send_beat(~d & {16{8'h7F}}, ~d & {16{8'h7F}}, 1'b0, 1'b1);
    wait_irq("irq_after_reset");
    cycles(1);
    csr_chk("status_after_reset", 8'h02, 32'h0002_0002);
    check("queue_empty", 130'(exp_q.size()), 130'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
